// File: rtl/and_gate_cell.sv
// Bitwise two-input AND with a registered copy, per-bit rise pulses and an optional
// saturating all-high cycle counter (enabled by defining AND_GATE_CELL_STATS_EN).
module and_gate_cell #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [WIDTH-1:0] y_rise,
    output logic             all_hi,
    output logic [CNT_W-1:0] hit_cnt
);

    // Elaboration-time guard on the supported parameter ranges
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("and_gate_cell: WIDTH must be in 1..64");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("and_gate_cell: CNT_W must be in 1..32");
    end

    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] r_y_q;
    logic [WIDTH-1:0] r_y_rise;

    // Glue path stays purely combinational so it works with the clock idle
    assign w_y    = a & b;
    assign y      = w_y;
    assign all_hi = &w_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_q    <= '0;
            r_y_rise <= '0;
        end else begin
            r_y_q    <= w_y;
            r_y_rise <= w_y & ~r_y_q;
        end
    end

    assign y_q    = r_y_q;
    assign y_rise = r_y_rise;

`ifdef AND_GATE_CELL_STATS_EN
    logic [CNT_W-1:0] r_hit_cnt;

    // Clear beats increment; the counter parks at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt <= '0;
        end else if (clr) begin
            r_hit_cnt <= '0;
        end else if (all_hi && (r_hit_cnt != {CNT_W{1'b1}})) begin
            r_hit_cnt <= r_hit_cnt + CNT_W'(1);
        end
    end

    assign hit_cnt = r_hit_cnt;
`else
    logic w_unused_clr;

    assign w_unused_clr = clr;
    assign hit_cnt      = '0;
`endif

endmodule

// File: tb/tb_and_gate_cell.sv
// Testbench for and_gate_cell: a WIDTH=1 instance for the idle-clock and pulse checks,
// and a WIDTH=4 / CNT_W=2 instance driven against a behavioural model.
module tb_and_gate_cell;

    localparam int unsigned W1  = 1;
    localparam int unsigned C1  = 16;
    localparam int unsigned W4  = 4;
    localparam int unsigned C4  = 2;
    localparam int          MAX4 = (1 << C4) - 1;

    logic          clk = 1'b0;
    logic          clk_run = 1'b0;
    logic          rst;

    logic [W1-1:0] a1, b1, y1, yq1, yr1;
    logic          clr1, ah1;
    logic [C1-1:0] cnt1;

    logic [W4-1:0] a4, b4, y4, yq4, yr4;
    logic          clr4, ah4;
    logic [C4-1:0] cnt4;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model state for the WIDTH=4 instance
    logic [W4-1:0] m_yq;
    logic [W4-1:0] m_rise;
    int            m_cnt;

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    and_gate_cell #(.WIDTH(W1), .CNT_W(C1)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .clr(clr1),
        .y(y1), .y_q(yq1), .y_rise(yr1), .all_hi(ah1), .hit_cnt(cnt1)
    );

    and_gate_cell #(.WIDTH(W4), .CNT_W(C4)) u_w4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .clr(clr4),
        .y(y4), .y_q(yq4), .y_rise(yr4), .all_hi(ah4), .hit_cnt(cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int exp_cnt(input int c);
`ifdef AND_GATE_CELL_STATS_EN
        return c;
`else
        return 0;
`endif
    endfunction

    // One clock of the WIDTH=4 instance: drive, check comb outputs, clock, check registers
    task automatic step4(input logic [W4-1:0] ta, input logic [W4-1:0] tb,
                         input logic tclr, input logic trst);
        logic [W4-1:0] yv;
        yv   = ta & tb;
        a4   = ta;
        b4   = tb;
        clr4 = tclr;
        rst  = trst;
        #1;
        chk("w4_y", 32'(y4), 32'(yv));
        chk("w4_all_hi", 32'(ah4), 32'(yv == 4'hF));
        @(posedge clk);
        if (trst) begin
            m_yq   = '0;
            m_rise = '0;
            m_cnt  = 0;
        end else begin
            m_rise = yv & ~m_yq;
            m_yq   = yv;
            if (tclr) m_cnt = 0;
            else if (yv == 4'hF && m_cnt < MAX4) m_cnt = m_cnt + 1;
        end
        #1;
        chk("w4_y_q", 32'(yq4), 32'(m_yq));
        chk("w4_y_rise", 32'(yr4), 32'(m_rise));
        chk("w4_hit_cnt", 32'(cnt4), 32'(exp_cnt(m_cnt)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] tt;
        logic       do_clr, do_rst;
        logic [3:0] ra, rb;

        rst  = 1'b1;
        clr1 = 1'b0;
        clr4 = 1'b0;
        a4   = '0;
        b4   = '0;
        m_yq = '0;
        m_rise = '0;
        m_cnt = 0;

        // Clock idle: combinational truth table on the WIDTH=1 instance
        for (int i = 0; i < 4; i++) begin
            tt = 4'(i);
            a1 = tt[1];
            b1 = tt[0];
            #1;
            chk("w1_idle_y", 32'(y1), 32'(i == 3));
            chk("w1_idle_all_hi", 32'(ah1), 32'(i == 3));
            #9;
        end

        // Start clock, reset, then a=b=1 for three cycles
        clk_run = 1'b1;
        a1 = 1'b0;
        b1 = 1'b0;
        @(posedge clk);
        #1;
        chk("w1_rst_y_q", 32'(yq1), 32'd0);
        chk("w1_rst_y_rise", 32'(yr1), 32'd0);
        chk("w1_rst_cnt", 32'(cnt1), 32'd0);
        rst = 1'b0;
        a1  = 1'b1;
        b1  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            chk("w1_y_q", 32'(yq1), 32'd1);
            chk("w1_y_rise", 32'(yr1), 32'(i == 1));
            chk("w1_cnt", 32'(cnt1), 32'(exp_cnt(i)));
        end
        // 1->0->1 toggle gives a fresh pulse
        a1 = 1'b0;
        @(posedge clk);
        #1;
        chk("w1_fall_y_q", 32'(yq1), 32'd0);
        a1 = 1'b1;
        @(posedge clk);
        #1;
        chk("w1_retoggle_rise", 32'(yr1), 32'd1);

        // WIDTH=4 directed sequence
        step4(4'h0, 4'h0, 1'b0, 1'b1);
        step4(4'b1100, 4'b1010, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step4(4'hF, 4'hF, 1'b0, 1'b0);
        step4(4'hF, 4'hF, 1'b1, 1'b0);
        step4(4'hF, 4'hF, 1'b0, 1'b0);
        step4(4'hF, 4'hF, 1'b0, 1'b0);
        step4(4'hF, 4'hF, 1'b0, 1'b0);
        // Mid-run reset while outputs are high; y must keep following inputs
        step4(4'hF, 4'hF, 1'b0, 1'b1);
        step4(4'hF, 4'hF, 1'b0, 1'b0);

        // Randomized phase, biased toward all-high inputs
        for (int i = 0; i < 300; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) begin
                ra = 4'hF;
                rb = 4'hF;
            end
            do_clr = ($urandom_range(0, 7) == 0);
            do_rst = ($urandom_range(0, 24) == 0);
            step4(ra, rb, do_clr, do_rst);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/and_gate_cell.md
# and_gate_cell

Bitwise two-input AND with registered observation logic. The combinational output `y = a & b` serves as a glue-logic primitive and must remain correct when the clock is idle or left undriven. A registered copy, per-bit rising-edge pulses and an optional saturating "all-high" cycle counter support status and debug use.

## Interface
Parameters:
- `WIDTH`, default 1: bit width of `a`, `b`, `y`, `y_q`, `y_rise`; legal range 1–64.
- `CNT_W`, default 16: width of `hit_cnt`; legal range 1–32.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `clr`  in  1  synchronous clear of `hit_cnt`.
- `y`  out  WIDTH  combinational `a & b`.
- `y_q`  out  WIDTH  `y` registered by one cycle.
- `y_rise`  out  WIDTH  per-bit one-cycle pulse on a 0→1 transition of `y_q`.
- `all_hi`  out  1  combinational AND-reduction of `y`.
- `hit_cnt`  out  CNT_W  saturating count of cycles with `all_hi`=1.

## Operation
- `y[i] = a[i] & b[i]` for every bit.
  - Purely combinational; no dependence on `clk` or `rst`.
  - Truth table per bit: 00→0, 01→0, 10→0, 11→1.
- `all_hi = &y`. With WIDTH=1, `all_hi` equals `y`.
- Register update on each rising `clk`, if not in reset:
  - `y_q <= y`
  - `y_rise <= y & ~y_q`
- `hit_cnt` update on each rising `clk`, if not in reset, highest priority first:
  - `clr`=1: `hit_cnt <= 0`. Clear wins over a simultaneous increment.
  - else if `all_hi`=1 and `hit_cnt` < 2^CNT_W−1: `hit_cnt <= hit_cnt + 1`.
  - else: hold. The counter saturates at all-ones and never wraps.
- Reset (`rst`=1 at a rising edge):
  - `y_q`, `y_rise` and `hit_cnt` become 0.
  - `rst` has priority over `clr` and over counting.
  - `y` and `all_hi` keep following the inputs during reset.
- Reset asserted mid-operation discards all registered state on that edge. The first edge after reset deassertion evaluates `y_rise` against `y_q` = 0, so bits already high produce a rise pulse.

## Timing
- `y` and `all_hi`: zero-cycle latency, combinational path only.
- `y_q`: 1-cycle latency from `a`/`b`.
- `y_rise`: asserted in the same cycle that `y_q` first shows 1; lasts exactly one cycle per transition.
  - Held-high inputs produce no further pulses.
  - A 1→0→1 toggle over consecutive cycles produces a new pulse.
- `hit_cnt`: reflects `all_hi` sampled at the previous edge (1-cycle latency).
- Outputs after reset: `y_q`=0, `y_rise`=0, `hit_cnt`=0; `y` = `a & b`.

## Configuration
- Macro `AND_GATE_CELL_STATS_EN`.
  - Defined: `hit_cnt` and `clr` logic is implemented as described.
  - Undefined: no counter register is built; `hit_cnt` is tied to 0 and `clr` is ignored.
  - `y`, `all_hi`, `y_q` and `y_rise` behave identically in both builds.

## Test plan
- WIDTH=1, clock idle: drive a,b = 00, 01, 10, 11, holding each 10 time units → `y` = 0, 0, 0, 1 within the same interval.
- WIDTH=4: a=4'b1100, b=4'b1010 → `y`=4'b1000, `all_hi`=0; a=b=4'hF → `all_hi`=1.
- Clocked, WIDTH=1: a=b=1 applied for 3 cycles from reset → `y_q`=1 from cycle 1; `y_rise`=1 in cycle 1 only.
- STATS_EN, CNT_W=2: all_hi=1 held for 5 cycles → `hit_cnt` goes 1, 2, 3, 3, 3. Assert `clr` together with all_hi=1 → `hit_cnt`=0.
- Reset mid-run (`hit_cnt`=3, `y_q`=1): `rst`=1 for one edge → `y_q`=0, `y_rise`=0, `hit_cnt`=0, while `y` still equals `a & b`.
- Macro undefined: all_hi=1 for 10 cycles → `hit_cnt` stays 0.
